muldiv_sequencer: RTL

- Iterative unsigned multiply/divide sequencer for the EX stage of the pipelined core.
- Accepts one MUL/DIVU/REMU request at a time and runs it over 32 cycles, one add or subtract per cycle, on a private ALU instance.
- Signals busy so the hazard logic stalls the pipeline, then presents a 32-bit result for one done cycle.

---
 rtl/muldiv_sequencer_pkg.sv | 29 ++
 rtl/muldiv_sequencer_alu.sv | 28 ++
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer and its ALU:
// ALU operator codes, operation encodings, FSM states and the iteration count.
package muldiv_sequencer_pkg;

    localparam int ITER = 32;
    localparam int COUNT_W = 5;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_RSVD = 2'b01,
        OP_DIVU = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Small combinational ALU; the sequencer owns a private instance and only ever
// drives it with ADD or SUB.
module muldiv_sequencer_alu
    import muldiv_sequencer_pkg::*;
(
    input  alu_op_e     operatorIn,
    input  logic [31:0] data1In,
    input  logic [31:0] data2In,
    output logic [31:0] resultOut,
    output logic        lessOut,
    output logic        zeroOut
);

    always_comb begin
        resultOut = '0;
        case (operatorIn)
            ALU_ADD: resultOut = data1In + data2In;
            ALU_SUB: resultOut = data1In - data2In;
            ALU_AND: resultOut = data1In & data2In;
            ALU_OR:  resultOut = data1In | data2In;
            default: resultOut = '0;
        endcase
    end

    assign lessOut = (data1In < data2In);
    assign zeroOut = (resultOut == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MUL/DIVU/REMU sequencer: one ALU add or subtract per cycle
// over 32 cycles, with busy for pipeline stalls and a one-cycle done pulse.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        startIn,
    input  logic        abortIn,
    input  logic [1:0]  opIn,
    input  logic [31:0] src1In,
    input  logic [31:0] src2In,
    output logic        busyOut,
    output logic        doneOut,
    output logic [31:0] resultOut
);

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    op_e                  op_q, op_d;
    // acc doubles as the remainder, mcand as the quotient, mplier as the divisor.
    logic [31:0]          acc_q, acc_d;
    logic [31:0]          mcand_q, mcand_d;
    logic [31:0]          mplier_q, mplier_d;
    logic [31:0]          result_q, result_d;

    alu_op_e              aluOp;
    logic [31:0]          aluData1;
    logic [31:0]          aluData2;
    logic [31:0]          aluResult;
    logic                 aluLess;
    logic                 aluZeroUnused;
    logic [31:0]          partial;

    muldiv_sequencer_alu alu (
        .operatorIn (aluOp),
        .data1In    (aluData1),
        .data2In    (aluData2),
        .resultOut  (aluResult),
        .lessOut    (aluLess),
        .zeroOut    (aluZeroUnused)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;

        partial  = {acc_q[30:0], mcand_q[31]};
        aluOp    = ALU_ADD;
        aluData1 = acc_q;
        aluData2 = mcand_q;
        if (op_q[1]) begin
            aluOp    = ALU_SUB;
            aluData1 = partial;
            aluData2 = mplier_q;
        end

        case (state_q)
            S_IDLE: begin
                if (startIn && !abortIn) begin
                    if (opIn == OP_RSVD) begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end else if (opIn[1] && (src2In == '0)) begin
                        result_d = (opIn == OP_DIVU) ? 32'hFFFF_FFFF : src1In;
                        state_d  = S_DONE;
                    end else begin
                        op_d     = op_e'(opIn);
                        acc_d    = '0;
                        mcand_d  = src1In;
                        mplier_d = src2In;
                        count_d  = '0;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (op_q == OP_MUL) begin
                    if (mplier_q[0]) begin
                        acc_d = aluResult;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    // A set rem[31] means the partial remainder really has 33 bits and always exceeds the divisor.
                    if (acc_q[31] || !aluLess) begin
                        acc_d   = aluResult;
                        mcand_d = {mcand_q[30:0], 1'b1};
                    end else begin
                        acc_d   = partial;
                        mcand_d = {mcand_q[30:0], 1'b0};
                    end
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_DIVU) ? mcand_d : acc_d;
                end
                if (abortIn) begin
                    state_d  = S_IDLE;
                    result_d = result_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
        end
    end

    assign busyOut   = (state_q != S_IDLE);
    assign doneOut   = (state_q == S_DONE);
    assign resultOut = result_q;

endmodule
